// File: rtl/cnt_pkg.sv
// Shared types for the cnt library counters.
package cnt_pkg;

    localparam int unsigned CNT_DW_DEFAULT = 8;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } cnt_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cnt_dn_state_e;

endpackage : cnt_pkg

// File: rtl/counter_down_core.sv
// Count register with synchronous clear, load and decrement-if-nonzero.
module counter_down_core #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          dec,
    output logic [DW-1:0] cnt,
    output logic          zero_c
);

    // Clear wins over load, load over decrement; zero never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - DW'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule : counter_down_core

// File: rtl/counter_down_reload.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
module counter_down_reload
    import cnt_pkg::*;
#(
    parameter int unsigned DW = CNT_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [DW-1:0] load_val,
    input  logic          load_mode,
    input  logic          en,
    input  logic          stop,
    output logic [DW-1:0] cnt,
    output logic          bo,
    output logic          busy,
    output logic          done
);

    cnt_dn_state_e state_q, state_d;
    cnt_mode_e     mode_q, mode_d;
    logic [DW-1:0] reload_q, reload_d;
    logic          done_d;

    logic          core_clear;
    logic          core_load;
    logic [DW-1:0] core_val;
    logic          core_dec;
    logic          zero_c;
    logic          run;
    logic          accept;

    counter_down_core #(
        .DW (DW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (core_clear),
        .load     (core_load),
        .load_val (core_val),
        .dec      (core_dec),
        .cnt      (cnt),
        .zero_c   (zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ONESHOT;
            reload_q <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            reload_q <= reload_d;
            done     <= done_d;
        end
    end

    // Priority: stop, then accept, then count/reload; a load may land on the borrow cycle.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        reload_d   = reload_q;
        done_d     = 1'b0;
        core_clear = 1'b0;
        core_load  = 1'b0;
        core_val   = reload_q;
        core_dec   = 1'b0;

        run        = (state_q == ST_RUN);
        busy       = run;
        bo         = run & en & zero_c & ~stop;
        load_ready = ~stop & (~run | bo);
        accept     = load_valid & load_ready;

        if (stop) begin
            state_d    = ST_IDLE;
            core_clear = 1'b1;
        end else if (accept) begin
            state_d   = ST_RUN;
            mode_d    = cnt_mode_e'(load_mode);
            reload_d  = load_val;
            core_load = 1'b1;
            core_val  = load_val;
        end else if (run && en) begin
            if (zero_c) begin
                if (mode_q == MODE_PERIODIC) begin
                    core_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                core_dec = 1'b1;
            end
        end
    end

endmodule : counter_down_reload

// File: tb/tb_counter_down_reload.sv
// Scenario bench for counter_down_reload with a per-cycle expectation queue.
module tb_counter_down_reload;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [DW-1:0] cnt;
        logic          bo;
        logic          busy;
        logic          done;
        logic          load_ready;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] load_val = '0;
    logic          load_mode = 1'b0;
    logic          en = 1'b0;
    logic          stop = 1'b0;
    logic [DW-1:0] cnt;
    logic          bo;
    logic          busy;
    logic          done;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t got;
    obs_t want;

    always #5 clk = ~clk;

    counter_down_reload #(.DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .load_mode  (load_mode),
        .en         (en),
        .stop       (stop),
        .cnt        (cnt),
        .bo         (bo),
        .busy       (busy),
        .done       (done)
    );

    function automatic obs_t mk(input int c, input logic b, input logic bz,
                                input logic d, input logic r);
        obs_t o;
        o.cnt        = DW'(c);
        o.bo         = b;
        o.busy       = bz;
        o.done       = d;
        o.load_ready = r;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.cnt        = cnt;
        o.bo         = bo;
        o.busy       = busy;
        o.done       = done;
        o.load_ready = load_ready;
        return o;
    endfunction

    // Apply one cycle of inputs on the falling edge, settle before sampling.
    task automatic drive(input logic lv, input int lval, input logic lm,
                         input logic e, input logic s);
        @(negedge clk);
        load_valid = lv;
        load_val   = DW'(lval);
        load_mode  = lm;
        en         = e;
        stop       = s;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                     got.cnt, got[3:0], want.cnt, want[3:0]);
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_oneshot();
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        for (int c = 3; c >= 0; c--) exp_q.push_back(mk(c, c == 0, 1, 0, c == 0));
        exp_q.push_back(mk(0, 0, 0, 1, 1));
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 3, 1'b0, 1'b1, 1'b0);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL oneshot[%0d]: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                         i, got.cnt, got[3:0], want.cnt, want[3:0]);
            end
        end
    endtask

    task automatic test_periodic();
        int c;
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        c = 2;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(mk(c, c == 0, 1, 0, c == 0));
            c = (c == 0) ? 2 : c - 1;
        end
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, 2, 1'b1, 1'b1, 1'b0);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL periodic[%0d]: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                         i, got.cnt, got[3:0], want.cnt, want[3:0]);
            end
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_en_toggle();
        int   c;
        int   bo_at;
        int   enabled;
        logic e;
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        c = 5; enabled = 0; bo_at = -1;
        for (int i = 0; i < 16; i++) begin
            e = (i % 2) == 0;
            exp_q.push_back(mk(c, e && c == 0, 1, 0, e && c == 0));
            if (e) begin
                enabled++;
                if (c == 0 && bo_at < 0) bo_at = enabled;
                c = (c == 0) ? 5 : c - 1;
            end
        end
        for (int i = 0; i < 17; i++) begin
            drive(i == 0, 5, 1'b1, (i == 0) || (((i - 1) % 2) == 0), 1'b0);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL en_toggle[%0d]: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                         i, got.cnt, got[3:0], want.cnt, want[3:0]);
            end
        end
        checks++;
        if (bo_at !== 6) begin
            errors++;
            $display("FAIL en_toggle_period: got %0d want 6", bo_at);
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        exp_q.push_back(mk(1, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 1, 1, 0, 1));
        exp_q.push_back(mk(4, 0, 1, 0, 0));
        exp_q.push_back(mk(3, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b1, 1, 1'b1, 1'b1, 1'b0);
            else        drive(i <= 2, 4, 1'b1, 1'b1, 1'b0);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                         i, got.cnt, got[3:0], want.cnt, want[3:0]);
            end
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stop();
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        for (int c = 7; c > 4; c--) exp_q.push_back(mk(c, 0, 1, 0, 0));
        exp_q.push_back(mk(4, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      drive(1'b1, 7, 1'b0, 1'b1, 1'b0);
            else if (i == 4) drive(1'b1, 9, 1'b1, 1'b1, 1'b1);
            else             drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stop[%0d]: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                         i, got.cnt, got[3:0], want.cnt, want[3:0]);
            end
        end
    endtask

    task automatic test_zero_and_reset();
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(0, 1, 1, 0, 1));
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, 0, 1'b1, 1'b1, 1'b0);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_zero[%0d]: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                         i, got.cnt, got[3:0], want.cnt, want[3:0]);
            end
        end
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 9, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        got = sample(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                     got.cnt, got[3:0], want.cnt, want[3:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1'b0, 1'b1, 1'b0);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL post_reset[%0d]: got cnt=%0d bo,busy,done,rdy=%b want cnt=%0d %b",
                         i, got.cnt, got[3:0], want.cnt, want[3:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_en_toggle();
        test_back_to_back();
        test_stop();
        test_zero_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_down_reload
